// File: rtl/osc_trig_gen_if.sv
// Bus between the oscilloscope control logic and the level-trigger generator:
// ADC sample streams and trigger configuration in, comparator/trigger status out.
interface osc_trig_gen_if #(
  parameter int HOLD_W = 16
);
  logic              Sample_Valid;
  logic [7:0]        ADC1_Data;
  logic [7:0]        ADC2_Data;
  logic              Arm;
  logic              Trig_Src;
  logic              Trig_Edge;
  logic              Auto;
  logic [7:0]        Trig_Level;
  logic [3:0]        Trig_Hyst;
  logic [HOLD_W-1:0] Holdoff;
  logic [1:0]        Trig_Out;
  logic              Trig_Pulse;
  logic              Trig_Auto;
  logic              Armed;

  modport master (
    output Sample_Valid, ADC1_Data, ADC2_Data, Arm, Trig_Src, Trig_Edge, Auto,
           Trig_Level, Trig_Hyst, Holdoff,
    input  Trig_Out, Trig_Pulse, Trig_Auto, Armed
  );

  modport slave (
    input  Sample_Valid, ADC1_Data, ADC2_Data, Arm, Trig_Src, Trig_Edge, Auto,
           Trig_Level, Trig_Hyst, Holdoff,
    output Trig_Out, Trig_Pulse, Trig_Auto, Armed
  );
endinterface

// File: rtl/osc_trig_gen.sv
// Level trigger with per-channel hysteresis comparators, holdoff and auto-trigger
// timeout, producing a single-cycle qualified trigger strobe for the capture stage.
module osc_trig_gen #(
  parameter int AUTO_TIMEOUT = 4096,
  parameter int HOLD_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  osc_trig_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cmp_q, cmp_d;
  logic [7:0]        level_q;
  logic [3:0]        hyst_q;
  logic              src_q, edge_q, auto_q;
  logic [HOLD_W-1:0] holdoff_q;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [15:0]       toCnt_q, toCnt_d;
  logic              pulse_q, pulse_d;
  logic              autoFlag_q, autoFlag_d;

  logic              loadCfg;
  logic [7:0]        effLevel, lvlHi, lvlLo;
  logic [3:0]        effHyst;
  logic [8:0]        sumHi;
  logic              selOld, selNew, edgeHit, toHit;
  logic [16:0]       toNext;

  // While idle the comparators follow the live settings; once armed they use the snapshot.
  assign loadCfg  = (state_q == IDLE) && bus.Arm;
  assign effLevel = (state_q == IDLE) ? bus.Trig_Level : level_q;
  assign effHyst  = (state_q == IDLE) ? bus.Trig_Hyst  : hyst_q;
  assign sumHi    = {1'b0, effLevel} + {5'b0, effHyst};
  assign lvlHi    = sumHi[8] ? 8'hFF : sumHi[7:0];
  assign lvlLo    = (effLevel >= {4'b0, effHyst}) ? (effLevel - {4'b0, effHyst}) : 8'h00;

  always_comb begin
    cmp_d = cmp_q;
    if (bus.Sample_Valid) begin
      if (!cmp_q[0] && (bus.ADC1_Data >= lvlHi))     cmp_d[0] = 1'b1;
      else if (cmp_q[0] && (bus.ADC1_Data <= lvlLo)) cmp_d[0] = 1'b0;
      if (!cmp_q[1] && (bus.ADC2_Data >= lvlHi))     cmp_d[1] = 1'b1;
      else if (cmp_q[1] && (bus.ADC2_Data <= lvlLo)) cmp_d[1] = 1'b0;
    end
  end

  assign selOld  = src_q ? cmp_q[1] : cmp_q[0];
  assign selNew  = src_q ? cmp_d[1] : cmp_d[0];
  assign edgeHit = bus.Sample_Valid && (edge_q ? (selOld && !selNew) : (!selOld && selNew));
  assign toNext  = {1'b0, toCnt_q} + 17'd1;
  assign toHit   = auto_q && bus.Sample_Valid && (toNext == 17'(AUTO_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.Arm) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (edgeHit || toHit) state_d = HOLDOFF;
        HOLDOFF: if (holdCnt_q == holdoff_q) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // A real edge takes priority over a timeout landing on the same strobe.
  always_comb begin
    holdCnt_d  = holdCnt_q;
    toCnt_d    = toCnt_q;
    pulse_d    = 1'b0;
    autoFlag_d = 1'b0;
    if (!bus.Arm) begin
      holdCnt_d = '0;
      toCnt_d   = '0;
    end else begin
      case (state_q)
        ARMED: begin
          holdCnt_d = '0;
          if (edgeHit) begin
            pulse_d = 1'b1;
            toCnt_d = '0;
          end else if (toHit) begin
            pulse_d    = 1'b1;
            autoFlag_d = 1'b1;
            toCnt_d    = '0;
          end else if (auto_q && bus.Sample_Valid) begin
            toCnt_d = toNext[15:0];
          end
        end
        HOLDOFF: begin
          if (holdCnt_q == holdoff_q)  holdCnt_d = '0;
          else if (bus.Sample_Valid)   holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
        default: begin
          holdCnt_d = '0;
          toCnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q      <= 2'b00;
      holdCnt_q  <= '0;
      toCnt_q    <= '0;
      pulse_q    <= 1'b0;
      autoFlag_q <= 1'b0;
      level_q    <= '0;
      hyst_q     <= '0;
      src_q      <= 1'b0;
      edge_q     <= 1'b0;
      auto_q     <= 1'b0;
      holdoff_q  <= '0;
    end else begin
      cmp_q      <= cmp_d;
      holdCnt_q  <= holdCnt_d;
      toCnt_q    <= toCnt_d;
      pulse_q    <= pulse_d;
      autoFlag_q <= autoFlag_d;
      if (loadCfg) begin
        level_q   <= bus.Trig_Level;
        hyst_q    <= bus.Trig_Hyst;
        src_q     <= bus.Trig_Src;
        edge_q    <= bus.Trig_Edge;
        auto_q    <= bus.Auto;
        holdoff_q <= bus.Holdoff;
      end
    end
  end

  assign bus.Trig_Out   = cmp_q;
  assign bus.Trig_Pulse = pulse_q;
  assign bus.Trig_Auto  = autoFlag_q;
  assign bus.Armed      = (state_q == ARMED);

endmodule

// File: tb/tb_osc_trig_gen.sv
// Testbench for osc_trig_gen: scenario tasks compare the DUT against a per-strobe
// behavioural model of the trigger rules.
module tb_osc_trig_gen;
  localparam int AUTO_TO = 16;
  localparam int HW      = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  osc_trig_gen_if #(.HOLD_W(HW)) bus ();

  osc_trig_gen #(.AUTO_TIMEOUT(AUTO_TO), .HOLD_W(HW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: armed flag, strobes left to ignore, strobes waited since arm/trigger.
  bit       mArmed;
  int       mHoldLeft, mWait;
  bit [1:0] mCmp;
  int       mLevel, mHyst, mHold;
  bit       mSrc, mEdge, mAuto;

  logic [5:0] obs, expv;
  logic [3:0] obsNow, expNow;
  logic       obsArmed, obsPulseAfter, expArmed, armObs;

  task automatic modelReset();
    mArmed = 0; mHoldLeft = 0; mWait = 0; mCmp = 2'b00;
    mLevel = 0; mHyst = 0; mHold = 0; mSrc = 0; mEdge = 0; mAuto = 0;
  endtask

  task automatic modelStrobe(input logic [7:0] a1, input logic [7:0] a2,
                             output logic [3:0] eNow, output logic eArmed);
    int lvl, hy, hi, lo, d;
    bit [1:0] old;
    bit pulse, autoF, hit;
    lvl = mArmed ? mLevel : int'(bus.Trig_Level);
    hy  = mArmed ? mHyst  : int'(bus.Trig_Hyst);
    hi  = (lvl + hy > 255) ? 255 : lvl + hy;
    lo  = (lvl - hy < 0) ? 0 : lvl - hy;
    old = mCmp;
    for (int ch = 0; ch < 2; ch++) begin
      d = (ch == 0) ? int'(a1) : int'(a2);
      if (!mCmp[ch] && d >= hi)     mCmp[ch] = 1'b1;
      else if (mCmp[ch] && d <= lo) mCmp[ch] = 1'b0;
    end
    pulse = 0; autoF = 0;
    if (mArmed) begin
      if (mHoldLeft > 0) begin
        mHoldLeft--;
      end else begin
        hit = mEdge ? (old[mSrc] && !mCmp[mSrc]) : (!old[mSrc] && mCmp[mSrc]);
        if (hit) pulse = 1;
        else if (mAuto) begin
          mWait++;
          if (mWait >= AUTO_TO) begin pulse = 1; autoF = 1; end
        end
        if (pulse) begin mWait = 0; mHoldLeft = mHold; end
      end
    end
    eNow   = {mCmp, pulse, autoF};
    eArmed = mArmed && (mHoldLeft == 0);
  endtask

  task automatic applyStimulus(input logic [7:0] a1, input logic [7:0] a2,
                               output logic [3:0] oNow, output logic oArmed,
                               output logic oPulseAfter);
    @(negedge clk);
    bus.ADC1_Data = a1; bus.ADC2_Data = a2; bus.Sample_Valid = 1'b1;
    @(negedge clk);
    bus.Sample_Valid = 1'b0;
    oNow = {bus.Trig_Out, bus.Trig_Pulse, bus.Trig_Auto};
    @(negedge clk);
    oArmed = bus.Armed;
    oPulseAfter = bus.Trig_Pulse;
  endtask

  task automatic setArm(input bit v, output logic oArmed);
    @(negedge clk);
    bus.Arm = v;
    if (v && !mArmed) begin
      mLevel = bus.Trig_Level; mHyst = bus.Trig_Hyst; mSrc = bus.Trig_Src;
      mEdge = bus.Trig_Edge; mAuto = bus.Auto; mHold = int'(bus.Holdoff);
      mHoldLeft = 0; mWait = 0;
    end
    mArmed = v;
    @(negedge clk);
    oArmed = bus.Armed;
  endtask

  task automatic setConfig(input int lvl, input int hy, input bit src, input bit edg,
                           input bit au, input int hold);
    @(negedge clk);
    bus.Trig_Level = 8'(lvl); bus.Trig_Hyst = 4'(hy); bus.Trig_Src = src;
    bus.Trig_Edge = edg; bus.Auto = au; bus.Holdoff = HW'(hold);
  endtask

  task automatic strobe(input logic [7:0] a1, input logic [7:0] a2);
    applyStimulus(a1, a2, obsNow, obsArmed, obsPulseAfter);
    modelStrobe(a1, a2, expNow, expArmed);
    obs  = {obsNow, obsArmed, obsPulseAfter};
    expv = {expNow, expArmed, 1'b0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Sample_Valid = 1'b0; bus.ADC1_Data = 8'd200; bus.ADC2_Data = 8'd0; bus.Arm = 1'b0;
    bus.Trig_Src = 0; bus.Trig_Edge = 0; bus.Auto = 0; bus.Trig_Level = 8'd100;
    bus.Trig_Hyst = 4'd4; bus.Holdoff = '0;
    modelReset();
    @(negedge clk); bus.Sample_Valid = 1'b1;
    @(negedge clk); bus.Sample_Valid = 1'b0;
    compared++;
    if ({bus.Trig_Out, bus.Trig_Pulse, bus.Trig_Auto, bus.Armed} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_values got %b want 00000",
               {bus.Trig_Out, bus.Trig_Pulse, bus.Trig_Auto, bus.Armed});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if ({bus.Trig_Out, bus.Trig_Pulse, bus.Trig_Auto, bus.Armed} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_idle got %b want 00000",
               {bus.Trig_Out, bus.Trig_Pulse, bus.Trig_Auto, bus.Armed});
    end
    strobe(8'd200, 8'd0);
    compared++;
    if (obs !== expv || obsNow !== 4'b0100) begin
      mismatched++;
      $display("[TB] FAIL reset_first_strobe got %b want %b", obs, expv);
    end
  endtask

  task automatic test_ramp();
    int pulseAt = -1, pulses = 0;
    setConfig(100, 4, 0, 0, 0, 0);
    strobe(8'd0, 8'd0);
    setArm(1, armObs);
    compared++;
    if (armObs !== 1'b1) begin mismatched++; $display("[TB] FAIL ramp_arm got %b want 1", armObs); end
    for (int i = 0; i < 256; i++) begin
      strobe(8'(i), 8'($urandom_range(0, 255)));
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL ramp_strobe s=%0d got %b want %b", i, obs, expv);
      end
      if (obsNow[1]) begin pulses++; if (pulseAt < 0) pulseAt = i; end
    end
    compared++;
    if (pulseAt !== 104 || pulses !== 1) begin
      mismatched++;
      $display("[TB] FAIL ramp_pulse_at got %0d (count %0d) want 104 (count 1)", pulseAt, pulses);
    end
  endtask

  task automatic test_hysteresis();
    int clearAt = -1, setAt = -1, toggles = 0;
    logic prev;
    setArm(0, armObs);
    setConfig(100, 4, 0, 0, 0, 0);
    setArm(1, armObs);
    for (int i = 0; i <= 40; i++) begin
      int v = (i <= 20) ? 110 - i : 90 + (i - 20);
      prev = mCmp[0];
      strobe(8'(v), 8'd0);
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL hyst_sweep v=%0d got %b want %b", v, obs, expv);
      end
      if (prev && !obsNow[2] && clearAt < 0) clearAt = v;
      if (!prev && obsNow[2] && setAt < 0) setAt = v;
    end
    compared++;
    if (clearAt !== 96 || setAt !== 104) begin
      mismatched++;
      $display("[TB] FAIL hyst_points got clear=%0d set=%0d want clear=96 set=104", clearAt, setAt);
    end
    for (int i = 0; i < 40; i++) begin
      strobe(8'($urandom_range(97, 103)), 8'd0);
      if (obsNow[2] !== 1'b1) toggles++;
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL hyst_noise i=%0d got %b want %b", i, obs, expv);
      end
    end
    compared++;
    if (toggles !== 0) begin mismatched++; $display("[TB] FAIL hyst_noise_toggles got %0d want 0", toggles); end
  endtask

  task automatic test_holdoff();
    int last = -100, minGap = 1000, pulses = 0;
    setArm(0, armObs);
    setConfig(100, 4, 0, 0, 0, 10);
    strobe(8'd50, 8'd0);
    setArm(1, armObs);
    for (int i = 0; i < 80; i++) begin
      strobe(((i / 2) % 2) ? 8'd150 : 8'd50, 8'($urandom_range(0, 255)));
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL holdoff_strobe i=%0d got %b want %b", i, obs, expv);
      end
      if (obsNow[1]) begin
        pulses++;
        if (i - last < minGap) minGap = i - last;
        last = i;
      end
    end
    compared++;
    if (pulses < 3 || minGap < 11) begin
      mismatched++;
      $display("[TB] FAIL holdoff_spacing got pulses=%0d gap=%0d want pulses>=3 gap>=11", pulses, minGap);
    end
  endtask

  task automatic test_auto();
    int autos = 0;
    int want = (80 - AUTO_TO) / (AUTO_TO + 3) + 1;
    setArm(0, armObs);
    setConfig(100, 4, 0, 0, 1, 3);
    setArm(1, armObs);
    for (int i = 0; i < 80; i++) begin
      strobe(8'd50, 8'd20);
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL auto_strobe i=%0d got %b want %b", i, obs, expv);
      end
      if (obsNow[1] && obsNow[0]) autos++;
    end
    compared++;
    if (autos !== want) begin mismatched++; $display("[TB] FAIL auto_count got %0d want %0d", autos, want); end
  endtask

  task automatic test_arm_drop();
    logic [7:0] seq [6] = '{8'd50, 8'd150, 8'd50, 8'd150, 8'd50, 8'd210};
    setArm(0, armObs);
    setConfig(100, 4, 0, 0, 0, 5);
    strobe(8'd50, 8'd0);
    setArm(1, armObs);
    strobe(8'd150, 8'd0);
    compared++;
    if (obs !== expv || obsNow[1] !== 1'b1) begin
      mismatched++; $display("[TB] FAIL drop_first_trigger got %b want %b", obs, expv);
    end
    setArm(0, armObs);
    compared++;
    if (armObs !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_in_holdoff got %b want 0", armObs); end
    for (int i = 0; i < 6; i++) begin
      strobe(seq[i], 8'd0);
      compared++;
      if (obs !== expv || obsNow[1] !== 1'b0) begin
        mismatched++; $display("[TB] FAIL drop_idle_strobe i=%0d got %b want %b", i, obs, expv);
      end
    end
    setConfig(200, 4, 0, 0, 0, 0);
    strobe(8'd50, 8'd0);
    setArm(1, armObs);
    setConfig(50, 4, 0, 0, 0, 0);
    strobe(8'd150, 8'd0);
    compared++;
    if (obs !== expv || obsNow[1] !== 1'b0) begin
      mismatched++; $display("[TB] FAIL relatch_ignore_live got %b want %b", obs, expv);
    end
    strobe(8'd210, 8'd0);
    compared++;
    if (obs !== expv || obsNow[1] !== 1'b1) begin
      mismatched++; $display("[TB] FAIL relatch_new_level got %b want %b", obs, expv);
    end
    strobe(8'd100, 8'd0);
    setArm(0, armObs);
    compared++;
    if (armObs !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_in_armed got %b want 0", armObs); end
    strobe(8'd0, 8'd0);
    strobe(8'd210, 8'd0);
    compared++;
    if (obs !== expv || obsNow[1] !== 1'b0) begin
      mismatched++; $display("[TB] FAIL drop_no_pulse got %b want %b", obs, expv);
    end
  endtask

  task automatic test_saturation();
    setArm(0, armObs);
    setConfig(253, 15, 0, 0, 0, 0);
    strobe(8'd0, 8'd100);
    setArm(1, armObs);
    strobe(8'd254, 8'd100);
    compared++;
    if (obs !== expv || obsNow[1] !== 1'b0) begin
      mismatched++; $display("[TB] FAIL sat_hi_254 got %b want %b", obs, expv);
    end
    strobe(8'd255, 8'd100);
    compared++;
    if (obs !== expv || obsNow[1] !== 1'b1) begin
      mismatched++; $display("[TB] FAIL sat_hi_255 got %b want %b", obs, expv);
    end
    setArm(0, armObs);
    setConfig(5, 15, 1, 1, 0, 0);
    strobe(8'd0, 8'd100);
    setArm(1, armObs);
    strobe(8'd0, 8'd1);
    compared++;
    if (obs !== expv || obsNow[1] !== 1'b0) begin
      mismatched++; $display("[TB] FAIL sat_lo_1 got %b want %b", obs, expv);
    end
    strobe(8'd0, 8'd0);
    compared++;
    if (obs !== expv || obsNow[1] !== 1'b1) begin
      mismatched++; $display("[TB] FAIL sat_lo_0 got %b want %b", obs, expv);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        setArm(!mArmed, armObs);
        compared++;
        if (armObs !== mArmed) begin
          mismatched++; $display("[TB] FAIL rand_arm i=%0d got %b want %b", i, armObs, mArmed);
        end
      end
      if (!mArmed && $urandom_range(0, 9) == 0)
        setConfig($urandom_range(0, 255), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 6));
      strobe(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      compared++;
      if (obs !== expv) begin
        mismatched++; $display("[TB] FAIL rand_strobe i=%0d got %b want %b", i, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_hysteresis();
    test_holdoff();
    test_auto();
    test_arm_drop();
    test_saturation();
    setArm(0, armObs);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/osc_trig_gen.md
# osc_trig_gen

Digital level-trigger generator sitting directly upstream of the sample-capture/SRAM-write stage in the oscilloscope CPLD. It watches the two 8-bit ADC sample streams and applies a programmable level with hysteresis per channel. It drives per-channel comparator levels plus a single-cycle trigger pulse that the capture stage uses to start a 1024-point acquisition. Holdoff and auto-trigger are handled here, so the capture stage only sees clean, qualified edges.

## Interface
- AUTO_TIMEOUT, 4096: sample strobes without a qualifying edge before an auto trigger fires (Auto=1 only); 1..65535.
- HOLD_W, 16: width of Holdoff input and holdoff counter.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Sample_Valid  in  1  one-cycle strobe: ADC1_Data/ADC2_Data hold a new sample this cycle.
- ADC1_Data  in  8  CH1 sample, unsigned.
- ADC2_Data  in  8  CH2 sample, unsigned.
- Arm  in  1  level; high = trigger armed, low = idle.
- Trig_Src  in  1  0 = CH1, 1 = CH2.
- Trig_Edge  in  1  0 = rising, 1 = falling.
- Auto  in  1  1 = enable auto-trigger timeout.
- Trig_Level  in  8  threshold, unsigned.
- Trig_Hyst  in  4  hysteresis half-width, LSBs.
- Holdoff  in  HOLD_W  sample strobes to ignore after each trigger.
- Trig_Out  out  2  hysteretic comparator state, [0]=CH1, [1]=CH2.
- Trig_Pulse  out  1  one-cycle trigger strobe.
- Trig_Auto  out  1  high with Trig_Pulse when the trigger was forced by timeout.
- Armed  out  1  high in ARMED state.

## Operation
- Thresholds: Lvl_Hi = min(255, Trig_Level+Trig_Hyst), Lvl_Lo = max(0, Trig_Level−Trig_Hyst), computed in 9 bits and saturated.
- Comparator per channel, updated only on Sample_Valid: if state 0 and data ≥ Lvl_Hi → 1; if state 1 and data ≤ Lvl_Lo → 0; otherwise hold. Trig_Hyst=0 gives a plain compare, set at ≥ Level, clear at ≤ Level.
- Config latch: Trig_Level, Trig_Hyst, Trig_Src, Trig_Edge, Auto and Holdoff are captured on the IDLE→ARMED transition. Changes while armed are ignored until the next arm.
- States:
  - IDLE: Armed=0, counters cleared. Goes to ARMED on the cycle after Arm is sampled high.
  - ARMED: Armed=1. A qualifying edge on the selected comparator (0→1 for rising, 1→0 for falling) asserts Trig_Pulse and goes to HOLDOFF. With Auto=1 the timeout counter increments per Sample_Valid; at AUTO_TIMEOUT it asserts Trig_Pulse and Trig_Auto and goes to HOLDOFF. A qualifying edge reached on the same strobe as the timeout counts as a real trigger (Trig_Auto=0). The timeout counter clears on every trigger.
  - HOLDOFF: counts Sample_Valid strobes up to the latched Holdoff, then goes to ARMED. Holdoff=0 returns to ARMED on the next cycle. Edges during HOLDOFF are discarded, not queued.
- Arm low in any state: go to IDLE next cycle, clear counters, no pulse. A comparator transition on the same cycle as the arm transition is not a qualifying edge.
- Comparators run continuously, independent of state and Arm.

## Timing
- Reset values: Trig_Out=2'b00, Trig_Pulse=0, Trig_Auto=0, Armed=0, state IDLE, all counters 0, latched config 0.
- Sample_Valid in cycle n gives Trig_Out updated at n+1. If qualifying, Trig_Pulse=1 at n+1 for exactly one cycle.
- Arm rises at cycle n: Armed=1 at n+1. The first strobe that can trigger is at n+1 or later.
- Holdoff=H: the first strobe eligible after a trigger is strobe H+1 after the triggering one.
- All outputs are registered; no combinational input→output path.
- Reset deasserting mid-stream: state starts at IDLE, the comparators restart from 0, and an input already above Lvl_Hi sets the comparator on the first strobe. A rising trigger fires from that only if already ARMED.

## Test plan
- Reset, then CH1 ramps 0→255 by 1 per strobe with Level=100, Hyst=4, rising, Src=0, armed: Trig_Out[0] sets on sample 104, a single Trig_Pulse at the same cycle, Trig_Auto=0.
- Hysteresis: CH1 sweeps 110→90→110, Level=100, Hyst=4: Trig_Out[0] clears at 96 and re-sets at 104. Noise of ±3 around 100 never toggles it.
- Holdoff=10, CH1 square wave toggling every 2 strobes: pulses are at least 11 strobes apart and no pulse occurs inside holdoff.
- Auto=1, AUTO_TIMEOUT=16, constant input 50, Level=100: Trig_Pulse and Trig_Auto every 16 strobes, with holdoff added between them.
- Arm dropped during HOLDOFF and while ARMED: Armed=0 next cycle and no pulse. On re-arm with new Level=200 the new threshold is used; Level changed while armed is ignored.
- Saturation: Level=253, Hyst=15, so Lvl_Hi=255. Falling edge on CH2 with Level=5, Hyst=15, so Lvl_Lo=0: triggers at 255 and 0 respectively.
